dbg_display_scan: RTL and testbench
===================================

Name: dbg_display_scan

Overview:
Parametrised debug-display engine that succeeds the separate register/memory-select and seven-segment decode path in the single-cycle CPU top level. It takes the flattened register-file and data-memory images and selects one word and one nibble window. It time-multiplexes DIGITS hex digits onto a common-anode seven-segment display. It adds tear-free frame snapshots, a freeze control and an auto-scan mode that walks every word/window pair.

Parameters:
WORDS, 32, words per image; power of two, at least 2
WORD_W, 32, bits per word; a multiple of 4*DIGITS
DIGITS, 4, number of display digits
REFRESH_DIV, 100000, clk cycles each digit stays lit; at least 2
AUTO_FRAMES, 64, frames per auto-scan step; at least 1
IDX_W, $clog2(WORDS), index width (derived)
WIN, WORD_W/(4*DIGITS), nibble windows per word (derived)
WIN_W, max(1,$clog2(WIN)), window-select width (derived)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
RF  in  WORDS*WORD_W  flattened register image; word i is RF[i*WORD_W +: WORD_W]
DM  in  WORDS*WORD_W  flattened data-memory image, same layout as RF
change  in  1  source select: 1 = RF, 0 = DM
choose  in  IDX_W  word index used in manual mode
level  in  WIN_W  nibble window in manual mode; 0 = least-significant window
auto_en  in  1  1 = auto-scan mode, 0 = manual mode
freeze  in  1  1 = hold the current snapshot
an  out  DIGITS  digit enables, active-low
seg  out  7  segment lines {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
cur_idx  out  IDX_W  word index currently shown
cur_win  out  WIN_W  window currently shown

Behaviour:
- Reset (rst=0, async): an all-ones, seg=7'h7F, dp=1, cur_idx=0, cur_win=0. All counters, the snapshot and the FSM clear; FSM goes to MANUAL.
- Refresh counter rc counts 0..REFRESH_DIV-1. Digit pointer dptr advances when rc wraps, and dptr wraps DIGITS-1 -> 0.
- A frame is DIGITS*REFRESH_DIV cycles. The frame-end strobe fe is high when rc==REFRESH_DIV-1 and dptr==DIGITS-1.
- Snapshot: a DIGITS*4-bit register.
  - Loaded in the first cycle after reset release.
  - Loaded on every fe when freeze=0.
  - Loaded value is the selected word's window bits [win*4*DIGITS +: 4*DIGITS].
  - Selection inputs and RF/DM changes are therefore visible only from the next frame. There is no mid-frame tearing.
- freeze=1 blocks snapshot loads and auto-scan steps. Scanning continues.
- Outputs are registered, with one cycle from dptr to an/seg.
  - an has exactly one bit low: an[dptr].
  - seg is the hex glyph of snapshot nibble dptr, where nibble 0 is the LSB and drives an[0].
  - Glyphs 0-F (active-low, g..a): 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
  - dp is low only on digit DIGITS-1 when change=1, which marks an RF source.
- FSM states: MANUAL and AUTO.
  - MANUAL: cur_idx and cur_win are loaded from choose and level on each fe.
  - MANUAL -> AUTO on fe when auto_en=1. cur_idx and cur_win start at 0, and the frame counter fc is cleared.
  - AUTO: fc counts frames. At fc==AUTO_FRAMES-1 on fe, fc clears and the position steps.
  - AUTO step order: cur_win increments. When cur_win wraps WIN-1 -> 0, cur_idx increments, wrapping WORDS-1 -> 0.
  - AUTO -> MANUAL on fe when auto_en=0.
  - Mode changes are sampled only at fe.
- Snapshot selection uses the cur_idx/cur_win values in effect after the same-edge update. A new position is therefore shown from the frame that starts at that edge.
- If level >= WIN (WIN not a power of two), window 0 is used.
- A reset mid-frame blanks the display immediately. Scanning restarts at dptr=0 and rc=0.

Decomposition:
- Package dbg_display_pkg holds:
  - the 16-entry active-low hex glyph constant array;
  - localparams SEG_BLANK=7'h7F and the MANUAL/AUTO state enum.
- One sub-module, seg_hex_glyph: combinational 4-bit to 7-bit lookup using the package table.
- The top part holds the counters, FSM, snapshot and output registers.

Test Plan:
- Reset check: hold rst=0 with random inputs, then pulse rst low mid-frame. Required: an=F, seg=7F and dp=1 throughout. After release, an[0] is low in the second cycle.
- Manual select, REFRESH_DIV=4, DIGITS=4, RF word 5=0x1234ABCD, change=1, choose=5, level=0. Required: digits show D,C,B,A with seg 21,46,03,08. With level=1 at the next frame: 4,3,2,1. dp is low only on an[3].
- Tear-free update: change DM word 3 from 0x0000FFFF to 0x00001111 mid-frame while change=0, choose=3. Required: the remainder of the frame shows F (seg 0E), and the next frame shows 1 (seg 79).
- Auto-scan, AUTO_FRAMES=2, WORDS=4, WIN=2, auto_en=1. Required: (cur_idx,cur_win) goes (0,0),(0,1),(1,0)...(3,1),(0,0), each pair held 2 frames. Dropping auto_en returns to choose/level at the next fe.
- Freeze: set freeze=1 in auto mode, change the RF image, run 10 frames. Required: cur_idx, cur_win and the glyphs are unchanged. After freeze=0, the new data shows from the next frame.
- Parameter sweep DIGITS=8, WORD_W=32, WIN=1. Required: all 8 digits scan in order and display the full word. an is always one-hot-low.

Source files
------------

// File: rtl/dbg_display_pkg.sv
// Shared constants and types for the debug seven-segment scan engine.
package dbg_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
    localparam logic [0:15][6:0] HEX_GLYPH = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        StManual,
        StAuto
    } scan_state_e;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dbg_display_scan_if.sv
// Source images, selection controls and display outputs of the scan engine.
interface dbg_display_scan_if #(
    parameter int unsigned WORDS  = 32,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DIGITS = 4
);
    import dbg_display_pkg::*;

    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam int unsigned WIN   = WORD_W / (4 * DIGITS);
    localparam int unsigned WIN_W = sel_width(WIN);

    logic [WORDS*WORD_W-1:0] i_rf;
    logic [WORDS*WORD_W-1:0] i_dm;
    logic                    i_change;
    logic [IDX_W-1:0]        i_choose;
    logic [WIN_W-1:0]        i_level;
    logic                    i_auto_en;
    logic                    i_freeze;
    logic [DIGITS-1:0]       o_an;
    logic [6:0]              o_seg;
    logic                    o_dp;
    logic [IDX_W-1:0]        o_cur_idx;
    logic [WIN_W-1:0]        o_cur_win;

    modport master (
        output i_rf, i_dm, i_change, i_choose, i_level, i_auto_en, i_freeze,
        input  o_an, o_seg, o_dp, o_cur_idx, o_cur_win
    );

    modport slave (
        input  i_rf, i_dm, i_change, i_choose, i_level, i_auto_en, i_freeze,
        output o_an, o_seg, o_dp, o_cur_idx, o_cur_win
    );

endinterface

// File: rtl/seg_hex_glyph.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module seg_hex_glyph
    import dbg_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_GLYPH[i_nibble];

endmodule

// File: rtl/dbg_display_scan.sv
// Multiplexed hex display of one RF/DM word window with frame snapshots,
// freeze control and an auto-scan mode walking every word/window pair.
module dbg_display_scan
    import dbg_display_pkg::*;
#(
    parameter int unsigned WORDS       = 32,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned AUTO_FRAMES = 64
) (
    input logic               clk,
    input logic               rst_n,
    dbg_display_scan_if.slave bus
);

    localparam int unsigned IDX_W  = $clog2(WORDS);
    localparam int unsigned WIN    = WORD_W / (4 * DIGITS);
    localparam int unsigned WIN_W  = sel_width(WIN);
    localparam int unsigned SNAP_W = 4 * DIGITS;
    localparam int unsigned RC_W   = $clog2(REFRESH_DIV);
    localparam int unsigned DPTR_W = sel_width(DIGITS);
    localparam int unsigned FC_W   = sel_width(AUTO_FRAMES);

    logic              r_started;
    logic [RC_W-1:0]   r_rc;
    logic [DPTR_W-1:0] r_dptr;
    logic [FC_W-1:0]   r_fc;
    logic [SNAP_W-1:0] r_snap;
    logic [DIGITS-1:0] r_an;
    logic [6:0]        r_seg;
    logic              r_dp;
    scan_state_e       r_state;
    logic [IDX_W-1:0]  r_cur_idx;
    logic [WIN_W-1:0]  r_cur_win;

    scan_state_e       w_state_d;
    logic [IDX_W-1:0]  w_idx_d;
    logic [WIN_W-1:0]  w_win_d;
    logic [FC_W-1:0]   w_fc_d;
    logic              w_rc_wrap;
    logic              w_last_digit;
    logic              w_fe;
    logic [WIN_W-1:0]  w_level;
    logic [WORD_W-1:0] w_word;
    logic [SNAP_W-1:0] w_sel;
    logic [3:0]        w_nibble;
    logic [6:0]        w_glyph;

    assign w_rc_wrap    = r_rc == RC_W'(REFRESH_DIV - 1);
    assign w_last_digit = r_dptr == DPTR_W'(DIGITS - 1);
    assign w_fe         = r_started && w_rc_wrap && w_last_digit;
    // Out-of-range windows only exist when WIN is not a power of two.
    assign w_level      = (32'(bus.i_level) >= WIN) ? '0 : bus.i_level;

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_cur_idx;
        w_win_d   = r_cur_win;
        w_fc_d    = r_fc;
        if (w_fe) begin
            case (r_state)
                StManual: begin
                    if (bus.i_auto_en) begin
                        w_state_d = StAuto;
                        w_idx_d   = '0;
                        w_win_d   = '0;
                        w_fc_d    = '0;
                    end else begin
                        w_idx_d = bus.i_choose;
                        w_win_d = w_level;
                    end
                end
                StAuto: begin
                    if (!bus.i_auto_en) begin
                        w_state_d = StManual;
                        w_idx_d   = bus.i_choose;
                        w_win_d   = w_level;
                    end else if (!bus.i_freeze) begin
                        if (r_fc == FC_W'(AUTO_FRAMES - 1)) begin
                            w_fc_d = '0;
                            if (r_cur_win == WIN_W'(WIN - 1)) begin
                                w_win_d = '0;
                                w_idx_d = r_cur_idx + IDX_W'(1);
                            end else begin
                                w_win_d = r_cur_win + WIN_W'(1);
                            end
                        end else begin
                            w_fc_d = r_fc + FC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Snapshot follows the position being committed on the same edge.
    assign w_word = bus.i_change ? bus.i_rf[32'(w_idx_d) * WORD_W +: WORD_W]
                                 : bus.i_dm[32'(w_idx_d) * WORD_W +: WORD_W];
    assign w_sel    = w_word[32'(w_win_d) * SNAP_W +: SNAP_W];
    assign w_nibble = r_snap[32'(r_dptr) * 4 +: 4];

    seg_hex_glyph u_glyph (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StManual;
            r_cur_idx <= '0;
            r_cur_win <= '0;
            r_fc      <= '0;
        end else begin
            r_state   <= w_state_d;
            r_cur_idx <= w_idx_d;
            r_cur_win <= w_win_d;
            r_fc      <= w_fc_d;
        end
    end

    // The first cycle after reset only primes the snapshot; scanning starts next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started <= 1'b0;
            r_rc      <= '0;
            r_dptr    <= '0;
            r_snap    <= '0;
            r_an      <= '1;
            r_seg     <= SEG_BLANK;
            r_dp      <= 1'b1;
        end else if (!r_started) begin
            r_started <= 1'b1;
            r_snap    <= w_sel;
        end else begin
            r_rc <= w_rc_wrap ? '0 : r_rc + RC_W'(1);
            if (w_rc_wrap) begin
                r_dptr <= w_last_digit ? '0 : r_dptr + DPTR_W'(1);
            end
            if (w_fe && !bus.i_freeze) begin
                r_snap <= w_sel;
            end
            r_an  <= ~(DIGITS'(1) << r_dptr);
            r_seg <= w_glyph;
            r_dp  <= ~(w_last_digit && bus.i_change);
        end
    end

    assign bus.o_an      = r_an;
    assign bus.o_seg     = r_seg;
    assign bus.o_dp      = r_dp;
    assign bus.o_cur_idx = r_cur_idx;
    assign bus.o_cur_win = r_cur_win;

endmodule

// File: tb/tb_dbg_display_scan.sv
// Two display engines (4 and 8 digits) fed the same images and controls,
// checked every cycle against a frame-level behavioural model.
module tb_dbg_display_scan;

    logic         clk;
    logic         rst_n;
    logic [127:0] rf;
    logic [127:0] dm;
    logic         change;
    logic [1:0]   choose;
    logic         level;
    logic         auto_en;
    logic         freeze;

    int n_checks = 0;
    int n_errors = 0;
    int n_edge   = 0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state per engine (0: 4 digits, 2 windows; 1: 8 digits, 1 window).
    bit          m_started [2];
    bit          m_auto    [2];
    int          m_t       [2];
    int          m_idx     [2];
    int          m_win     [2];
    int          m_fc      [2];
    logic [63:0] m_snap    [2];
    logic [63:0] m_an      [2];
    logic [63:0] m_seg     [2];
    logic [63:0] m_dp      [2];

    dbg_display_scan_if #(.WORDS(4), .WORD_W(32), .DIGITS(4)) bus_a ();
    dbg_display_scan_if #(.WORDS(4), .WORD_W(32), .DIGITS(8)) bus_b ();

    assign bus_a.i_rf = rf;      assign bus_b.i_rf = rf;
    assign bus_a.i_dm = dm;      assign bus_b.i_dm = dm;
    assign bus_a.i_change = change;   assign bus_b.i_change = change;
    assign bus_a.i_choose = choose;   assign bus_b.i_choose = choose;
    assign bus_a.i_level = level;     assign bus_b.i_level = level;
    assign bus_a.i_auto_en = auto_en; assign bus_b.i_auto_en = auto_en;
    assign bus_a.i_freeze = freeze;   assign bus_b.i_freeze = freeze;

    dbg_display_scan #(
        .WORDS(4), .WORD_W(32), .DIGITS(4), .REFRESH_DIV(4), .AUTO_FRAMES(2)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    dbg_display_scan #(
        .WORDS(4), .WORD_W(32), .DIGITS(8), .REFRESH_DIV(2), .AUTO_FRAMES(2)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running, expected done");
        $fatal(1, "timeout");
    end

    function automatic int dig_of(input int k);  return (k == 0) ? 4 : 8; endfunction
    function automatic int rdiv_of(input int k); return (k == 0) ? 4 : 2; endfunction
    function automatic int nwin_of(input int k); return (k == 0) ? 2 : 1; endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pick(input int k);
        logic [31:0] w;
        int          bits;
        w    = change ? rf[m_idx[k]*32 +: 32] : dm[m_idx[k]*32 +: 32];
        bits = 4 * dig_of(k);
        return (64'(w) >> (m_win[k] * bits)) & ((64'd1 << bits) - 64'd1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_started[k] = 1'b0;
            m_auto[k]    = 1'b0;
            m_t[k]       = 0;
            m_idx[k]     = 0;
            m_win[k]     = 0;
            m_fc[k]      = 0;
            m_snap[k]    = '0;
            m_an[k]      = (64'd1 << dig_of(k)) - 64'd1;
            m_seg[k]     = 64'h7F;
            m_dp[k]      = 64'd1;
        end
        n_edge = 0;
    endtask

    task automatic model_step(input int k);
        int d, frame, dig, nib, lv, flat;
        d     = dig_of(k);
        frame = d * rdiv_of(k);
        if (!m_started[k]) begin
            m_started[k] = 1'b1;
            m_snap[k]    = pick(k);
            return;
        end
        dig      = (m_t[k] / rdiv_of(k)) % d;
        nib      = int'((m_snap[k] >> (4 * dig)) & 64'hF);
        m_an[k]  = ((64'd1 << d) - 64'd1) & ~(64'd1 << dig);
        m_seg[k] = 64'(glyph[nib]);
        m_dp[k]  = (dig == d - 1 && change) ? 64'd0 : 64'd1;
        if (m_t[k] % frame == frame - 1) begin
            lv = (int'(level) >= nwin_of(k)) ? 0 : int'(level);
            if (!m_auto[k] && auto_en) begin
                m_auto[k] = 1'b1;
                m_idx[k]  = 0;
                m_win[k]  = 0;
                m_fc[k]   = 0;
            end else if (!m_auto[k] || !auto_en) begin
                m_auto[k] = 1'b0;
                m_idx[k]  = int'(choose);
                m_win[k]  = lv;
            end else if (!freeze) begin
                if (m_fc[k] == 1) begin
                    m_fc[k]  = 0;
                    flat     = m_idx[k] * nwin_of(k) + m_win[k] + 1;
                    m_idx[k] = (flat / nwin_of(k)) % 4;
                    m_win[k] = flat % nwin_of(k);
                end else begin
                    m_fc[k]++;
                end
            end
            if (!freeze) m_snap[k] = pick(k);
        end
        m_t[k]++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                model_step(0);
                model_step(1);
                n_edge++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("a.an", 64'(bus_a.o_an), m_an[0]);
            check("a.seg", 64'(bus_a.o_seg), m_seg[0]);
            check("a.dp", 64'(bus_a.o_dp), m_dp[0]);
            check("a.cur_idx", 64'(bus_a.o_cur_idx), 64'(m_idx[0]));
            check("a.cur_win", 64'(bus_a.o_cur_win), 64'(m_win[0]));
            check("b.an", 64'(bus_b.o_an), m_an[1]);
            check("b.seg", 64'(bus_b.o_seg), m_seg[1]);
            check("b.dp", 64'(bus_b.o_dp), m_dp[1]);
            check("b.cur_idx", 64'(bus_b.o_cur_idx), 64'(m_idx[1]));
            check("b.cur_win", 64'(bus_b.o_cur_win), 64'(m_win[1]));
        end
    end

    task automatic wait_edge(input int k);
        while (n_edge < k) @(negedge clk);
    endtask

    task automatic random_inputs();
        rf      = {$urandom, $urandom, $urandom, $urandom};
        dm      = {$urandom, $urandom, $urandom, $urandom};
        change  = 1'($urandom_range(1));
        choose  = 2'($urandom_range(3));
        level   = 1'($urandom_range(1));
        auto_en = 1'($urandom_range(1));
        freeze  = 1'($urandom_range(1));
    endtask

    initial begin
        rst_n = 1'b0;
        random_inputs();
        repeat (5) @(negedge clk);
        random_inputs();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_edge(1);
        check("lit.prime_blank", 64'(bus_a.o_an), 64'hF);
        wait_edge(2);
        check("lit.first_digit", 64'(bus_a.o_an), 64'hE);
        wait_edge(7);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("lit.rst_an_a", 64'(bus_a.o_an), 64'hF);
        check("lit.rst_seg_a", 64'(bus_a.o_seg), 64'h7F);
        check("lit.rst_dp_a", 64'(bus_a.o_dp), 64'h1);
        check("lit.rst_an_b", 64'(bus_b.o_an), 64'hFF);
        repeat (3) @(negedge clk);

        random_inputs();
        rf[2*32 +: 32] = 32'h1234ABCD;
        dm[0*32 +: 32] = 32'h00000007;
        change  = 1'b1;
        choose  = 2'd2;
        level   = 1'b0;
        auto_en = 1'b0;
        freeze  = 1'b0;
        #2 rst_n = 1'b1;

        wait_edge(18);
        check("lit.man_d0", 64'(bus_a.o_seg), 64'h21);
        check("lit.man_an0", 64'(bus_a.o_an), 64'hE);
        check("lit.b_d0", 64'(bus_b.o_seg), 64'h21);
        wait_edge(20);
        level = 1'b1;
        wait_edge(22);
        check("lit.man_d1", 64'(bus_a.o_seg), 64'h46);
        wait_edge(26);
        check("lit.man_d2", 64'(bus_a.o_seg), 64'h03);
        wait_edge(30);
        check("lit.man_d3", 64'(bus_a.o_seg), 64'h08);
        check("lit.man_an3", 64'(bus_a.o_an), 64'h7);
        check("lit.man_dp3", 64'(bus_a.o_dp), 64'h0);
        wait_edge(32);
        check("lit.b_d7", 64'(bus_b.o_seg), 64'h79);
        check("lit.b_an7", 64'(bus_b.o_an), 64'h7F);
        check("lit.b_dp7", 64'(bus_b.o_dp), 64'h0);
        wait_edge(34);
        check("lit.win1_d0", 64'(bus_a.o_seg), 64'h19);
        check("lit.win1_cur", 64'(bus_a.o_cur_win), 64'h1);

        wait_edge(40);
        change = 1'b0;
        choose = 2'd3;
        level  = 1'b0;
        dm[3*32 +: 32] = 32'h0000FFFF;
        wait_edge(50);
        check("lit.tear_f0", 64'(bus_a.o_seg), 64'h0E);
        check("lit.tear_idx", 64'(bus_a.o_cur_idx), 64'h3);
        wait_edge(57);
        dm[3*32 +: 32] = 32'h00001111;
        wait_edge(62);
        check("lit.tear_hold", 64'(bus_a.o_seg), 64'h0E);
        wait_edge(66);
        check("lit.tear_next", 64'(bus_a.o_seg), 64'h79);

        wait_edge(70);
        auto_en = 1'b1;
        wait_edge(81);
        check("lit.auto_idx0", 64'(bus_a.o_cur_idx), 64'h0);
        check("lit.auto_win0", 64'(bus_a.o_cur_win), 64'h0);
        wait_edge(113);
        check("lit.auto_win1", 64'(bus_a.o_cur_win), 64'h1);
        check("lit.b_auto_idx1", 64'(bus_b.o_cur_idx), 64'h1);
        wait_edge(145);
        check("lit.auto_10", {bus_a.o_cur_idx, bus_a.o_cur_win}, 64'h2);
        wait_edge(305);
        check("lit.auto_31", {bus_a.o_cur_idx, bus_a.o_cur_win}, 64'h7);
        wait_edge(337);
        check("lit.auto_wrap", {bus_a.o_cur_idx, bus_a.o_cur_win}, 64'h0);

        wait_edge(340);
        freeze = 1'b1;
        change = 1'b1;
        rf[0*32 +: 32] = 32'h00005A5A;
        wait_edge(500);
        check("lit.frz_pos", {bus_a.o_cur_idx, bus_a.o_cur_win}, 64'h0);
        check("lit.frz_seg", 64'(bus_a.o_seg), 64'h78);
        freeze = 1'b0;
        wait_edge(514);
        check("lit.unfrz_seg", 64'(bus_a.o_seg), 64'h08);
        wait_edge(520);
        auto_en = 1'b0;
        choose  = 2'd1;
        level   = 1'b1;
        wait_edge(529);
        check("lit.back_manual", {bus_a.o_cur_idx, bus_a.o_cur_win}, 64'h3);

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ($urandom_range(15) == 0) rf[$urandom_range(3)*32 +: 32] = $urandom;
            if ($urandom_range(15) == 0) dm[$urandom_range(3)*32 +: 32] = $urandom;
            if ($urandom_range(31) == 0) choose = 2'($urandom_range(3));
            if ($urandom_range(31) == 0) level = ~level;
            if ($urandom_range(31) == 0) change = ~change;
            if ($urandom_range(63) == 0) freeze = ~freeze;
            if ($urandom_range(127) == 0) auto_en = ~auto_en;
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
